// File: rtl/midori64_dec_controller.sv
// -----------------------------------------------------------------------------
// midori64_dec_controller
//
// Purpose:
//   Round controller for the masked, round-based Midori64 decryption datapath.
//   It accepts one masked ciphertext block through a valid/ready handshake.
//   It then sequences the datapath through NUM_ROUNDS rounds, counting the
//   round index down. Each round lasts SBOX_STAGES cycles so the pipelined
//   masked S-box can drain. The plaintext is then presented through an output
//   valid/ready handshake that supports backpressure.
//
// Parameters:
//   SBOX_STAGES : register stages in the masked S-box, i.e. cycles per round
//                 (1..15)
//   NUM_ROUNDS  : rounds per block, including the final S-layer round (2..16)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset, forces IDLE
//   in_valid    in   masked ciphertext and key shares valid on datapath inputs
//   in_ready    out  controller can accept a block (IDLE only)
//   load_sel    out  datapath state mux selects fresh input shares (LOAD only)
//   EN          out  datapath state/key register enable (LOAD and RUN)
//   round       out  current decryption round, NUM_ROUNDS-1 down to 0
//   stage       out  S-box pipeline stage within the round, 0..SBOX_STAGES-1
//   first_round out  RUN with round==NUM_ROUNDS-1
//   last_round  out  RUN with round==0 (final whitening key add)
//   busy        out  state is LOAD or RUN
//   out_valid   out  plaintext shares valid on datapath outputs (DONE)
//   out_ready   in   consumer accepts the plaintext
// -----------------------------------------------------------------------------
module midori64_dec_controller #(
    parameter int SBOX_STAGES = 3,
    parameter int NUM_ROUNDS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_sel,
    output logic       EN,
    output logic [3:0] round,
    output logic [3:0] stage,
    output logic       first_round,
    output logic       last_round,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    // The round and stage terminal values are kept as 4-bit constants so every
    // comparison against the counters has matching widths.
    localparam logic [3:0] ROUND_MAX = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] STAGE_MAX = 4'(SBOX_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_round;
    logic [3:0] r_stage;

    // Main sequencer. The round index starts at the top and counts down one
    // step whenever the S-box pipeline finishes a round. The block completes
    // when the round-0 pass ends. The round counter never goes below zero, so
    // it cannot wrap. DONE keeps everything frozen until the consumer takes
    // the result. Going back through IDLE is deliberate: a new block can be
    // accepted only on a later cycle, never straight out of DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_stage <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_LOAD;
                        r_round <= ROUND_MAX;
                        r_stage <= 4'd0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_stage == STAGE_MAX) begin
                        r_stage <= 4'd0;
                        if (r_round == 4'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_round <= r_round - 4'd1;
                        end
                    end else begin
                        r_stage <= r_stage + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_round <= 4'd0;
                    r_stage <= 4'd0;
                end
            endcase
        end
    end

    // Every output is decoded only from registered state and counters. No
    // handshake input reaches an output combinationally. Because the state
    // register is asynchronously reset, EN and busy drop as soon as reset
    // rises, without waiting for a clock edge.
    assign in_ready    = (r_state == S_IDLE);
    assign load_sel    = (r_state == S_LOAD);
    assign EN          = (r_state == S_LOAD) || (r_state == S_RUN);
    assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign out_valid   = (r_state == S_DONE);
    assign first_round = (r_state == S_RUN) && (r_round == ROUND_MAX);
    assign last_round  = (r_state == S_RUN) && (r_round == 4'd0);
    assign round       = r_round;
    assign stage       = r_stage;

endmodule

// File: tb/tb_midori64_dec_controller.sv
// -----------------------------------------------------------------------------
// tb_midori64_dec_controller
//
// Purpose:
//   Self-checking bench for midori64_dec_controller. Two instances share the
//   same stimulus: one with the default three-stage S-box and one with a
//   single-stage S-box.
//
//   The reference model for each instance is a single integer: the number of
//   clock edges since the block was accepted, or -1 when no block is in
//   flight. Every expected output is computed from that number with plain
//   arithmetic. The first edge after acceptance is the load cycle. The next
//   NUM_ROUNDS*SBOX_STAGES edges are the rounds. The edge after those is the
//   result cycle, which lasts until out_ready is seen.
// -----------------------------------------------------------------------------
module tb_midori64_dec_controller;

    localparam int NR = 16;
    localparam int SA = 3;
    localparam int SB = 1;

    logic clk;
    logic reset;
    logic inValid;
    logic outReady;

    logic       aInReady, aLoadSel, aEn, aFirst, aLast, aBusy, aOutValid;
    logic [3:0] aRound, aStage;
    logic       bInReady, bLoadSel, bEn, bFirst, bLast, bBusy, bOutValid;
    logic [3:0] bRound, bStage;

    int nVectors;
    int nMiscompares;
    int mA;
    int mB;

    midori64_dec_controller #(.SBOX_STAGES(SA), .NUM_ROUNDS(NR)) dutA (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(aInReady),
        .load_sel(aLoadSel), .EN(aEn), .round(aRound), .stage(aStage),
        .first_round(aFirst), .last_round(aLast), .busy(aBusy),
        .out_valid(aOutValid), .out_ready(outReady)
    );

    midori64_dec_controller #(.SBOX_STAGES(SB), .NUM_ROUNDS(NR)) dutB (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(bInReady),
        .load_sel(bLoadSel), .EN(bEn), .round(bRound), .stage(bStage),
        .first_round(bFirst), .last_round(bLast), .busy(bBusy),
        .out_valid(bOutValid), .out_ready(outReady)
    );

    // Free-running clock with a 10-time-unit period. Rising edges fall at 5,
    // 15, 25, ... in simulation time.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Computes the expected outputs from the number of edges since
    // acceptance, for an instance with s cycles per round.
    task automatic modelOutputs(input int cnt, input int s,
                                output logic [3:0] eRound, output logic [3:0] eStage,
                                output logic eInReady, output logic eLoad,
                                output logic eEn, output logic eBusy,
                                output logic eOutValid, output logic eFirst,
                                output logic eLast);
        int j;
        eRound = 4'd0; eStage = 4'd0;
        eInReady = 1'b0; eLoad = 1'b0; eEn = 1'b0; eBusy = 1'b0;
        eOutValid = 1'b0; eFirst = 1'b0; eLast = 1'b0;
        if (cnt < 0) begin
            eInReady = 1'b1;
        end else if (cnt == 0) begin
            eLoad = 1'b1; eEn = 1'b1; eBusy = 1'b1;
            eRound = 4'(NR - 1);
        end else if (cnt <= NR * s) begin
            j = cnt - 1;
            eRound = 4'(NR - 1 - j / s);
            eStage = 4'(j % s);
            eEn = 1'b1; eBusy = 1'b1;
            eFirst = (j / s == 0);
            eLast  = (j / s == NR - 1);
        end else begin
            eOutValid = 1'b1;
        end
    endtask

    // Advances one model by the inputs it sees at a rising edge.
    task automatic modelEdge(inout int cnt, input int s, input logic iv, input logic ordy);
        if (cnt < 0) begin
            if (iv) cnt = 0;
        end else if (cnt == NR * s + 1) begin
            if (ordy) cnt = -1;
        end else begin
            cnt = cnt + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input string ctx);
        logic [3:0] eR, eS;
        logic eIr, eL, eE, eB, eOv, eF, eLa;
        modelOutputs(mA, SA, eR, eS, eIr, eL, eE, eB, eOv, eF, eLa);
        chk({ctx, "/A.round"}, aRound, eR);
        chk({ctx, "/A.stage"}, aStage, eS);
        chk({ctx, "/A.in_ready"}, {3'b0, aInReady}, {3'b0, eIr});
        chk({ctx, "/A.load_sel"}, {3'b0, aLoadSel}, {3'b0, eL});
        chk({ctx, "/A.EN"}, {3'b0, aEn}, {3'b0, eE});
        chk({ctx, "/A.busy"}, {3'b0, aBusy}, {3'b0, eB});
        chk({ctx, "/A.out_valid"}, {3'b0, aOutValid}, {3'b0, eOv});
        chk({ctx, "/A.first_round"}, {3'b0, aFirst}, {3'b0, eF});
        chk({ctx, "/A.last_round"}, {3'b0, aLast}, {3'b0, eLa});
        modelOutputs(mB, SB, eR, eS, eIr, eL, eE, eB, eOv, eF, eLa);
        chk({ctx, "/B.round"}, bRound, eR);
        chk({ctx, "/B.stage"}, bStage, eS);
        chk({ctx, "/B.in_ready"}, {3'b0, bInReady}, {3'b0, eIr});
        chk({ctx, "/B.load_sel"}, {3'b0, bLoadSel}, {3'b0, eL});
        chk({ctx, "/B.EN"}, {3'b0, bEn}, {3'b0, eE});
        chk({ctx, "/B.busy"}, {3'b0, bBusy}, {3'b0, eB});
        chk({ctx, "/B.out_valid"}, {3'b0, bOutValid}, {3'b0, eOv});
        chk({ctx, "/B.first_round"}, {3'b0, bFirst}, {3'b0, eF});
        chk({ctx, "/B.last_round"}, {3'b0, bLast}, {3'b0, eLa});
    endtask

    // Drives the inputs for one cycle, steps both models at the rising edge,
    // and checks the outputs 1 time unit later.
    task automatic applyStimulus(input logic iv, input logic ordy, input string ctx);
        inValid  = iv;
        outReady = ordy;
        @(posedge clk);
        modelEdge(mA, SA, iv, ordy);
        modelEdge(mB, SB, iv, ordy);
        #1;
        checkOutput(ctx);
    endtask

    // Raises reset between clock edges and checks the outputs before any
    // edge arrives. It then holds reset across one edge and releases it away
    // from the edge.
    task automatic asyncReset(input string ctx);
        #2;
        reset = 1'b1;
        mA = -1;
        mB = -1;
        #1;
        checkOutput({ctx, "/async"});
        @(posedge clk);
        #1;
        checkOutput({ctx, "/held"});
        reset = 1'b0;
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        mA = -1;
        mB = -1;
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        #3;
        checkOutput("reset");
        @(posedge clk);
        #1;
        checkOutput("reset_edge");
        reset = 1'b0;

        $display("[TB] single block, one-cycle in_valid pulse, out_ready high");
        applyStimulus(1'b1, 1'b1, "t1");
        for (int i = 0; i < 55; i++) applyStimulus(1'b0, 1'b1, "t1");

        $display("[TB] backpressure on the result");
        applyStimulus(1'b1, 1'b0, "t2");
        for (int i = 0; i < 48 + 10; i++) applyStimulus(1'b0, 1'b0, "t2");
        applyStimulus(1'b0, 1'b1, "t2");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "t2");

        $display("[TB] in_valid held high continuously");
        for (int i = 0; i < 160; i++) applyStimulus(1'b1, 1'b1, "t3");
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, "t3");

        $display("[TB] asynchronous reset mid-run at round 7 stage 1");
        applyStimulus(1'b1, 1'b1, "t4");
        for (int i = 0; i < 60 && mA != 26; i++) applyStimulus(1'b0, 1'b1, "t4");
        nVectors++;
        assert (mA == 26) else begin
            nMiscompares++;
            $error("[TB] FAIL t4.reach observed=%0d expected=26", mA);
        end
        asyncReset("t4");
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, "t4_after");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                asyncReset("rnd");
            end else begin
                applyStimulus(1'(($urandom_range(0, 3) == 0) ? 1 : 0),
                              1'($urandom_range(0, 1)), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/midori64_dec_controller.md
Name: midori64_dec_controller

Overview:
- Control FSM for the masked round-based Midori64 decryption datapath, the inverse-direction counterpart of the encryption round controller.
- Accepts a masked ciphertext through a valid/ready handshake and drives the load-select, round index (counting down), pipeline-stage index and register enable.
- Presents the result through an output valid/ready handshake with backpressure.
- Sits between the host/share-generation interface and the masked decryption datapath. The datapath uses the same SBOX_STAGES-deep masked S-box pipeline as encryption.

Parameters:
SBOX_STAGES, 3, register stages in masked S-box; clock cycles per round (1..15)
NUM_ROUNDS, 16, rounds per block incl. final S-layer round (2..16)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE
in_valid  input  1  masked ciphertext shares and key shares valid on datapath inputs
in_ready  output  1  controller can accept a block
load_sel  output  1  datapath state mux selects fresh input shares (high only in LOAD)
EN  output  1  datapath state/key register enable
round  output  4  current decryption round index, NUM_ROUNDS-1 down to 0
stage  output  4  S-box pipeline stage within round, 0..SBOX_STAGES-1
first_round  output  1  round==NUM_ROUNDS-1 in RUN (datapath omits inverse MixColumn/first-key handling)
last_round  output  1  round==0 in RUN (final whitening key add)
busy  output  1  state is LOAD or RUN
out_valid  output  1  plaintext shares valid on datapath outputs
out_ready  input  1  consumer accepts plaintext

Behaviour:
- Reset (async, any state): state=IDLE, round=0, stage=0.
  - Outputs while in reset/IDLE: in_ready=1, load_sel=0, EN=0, busy=0, out_valid=0, first_round=0, last_round=0.
- Every output is decoded from registered state/counters; no combinational path from in_valid/out_ready to any output.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid=1 at a clock edge: go to LOAD, round<=NUM_ROUNDS-1, stage<=0.
  - LOAD (exactly 1 cycle):
    - load_sel=1, EN=1, busy=1, in_ready=0.
    - Next state is RUN. round and stage are unchanged.
  - RUN:
    - EN=1, busy=1, load_sel=0.
    - Each cycle stage<=stage+1.
    - When stage==SBOX_STAGES-1:
      - stage<=0.
      - If round==0: go to DONE.
      - Otherwise round<=round-1.
    - round is never decremented below 0. No wrap to 15.
  - DONE:
    - out_valid=1, EN=0, in_ready=0, busy=0. round=0 and stage=0 are held.
    - On out_ready=1: go to IDLE.
    - While out_ready=0, hold indefinitely. EN stays 0, so the datapath output is frozen.
- Latency:
  - Accepting edge at T0.
  - LOAD covers cycle T0..T1.
  - RUN lasts NUM_ROUNDS*SBOX_STAGES cycles.
  - out_valid first high after edge T0+1+NUM_ROUNDS*SBOX_STAGES. With defaults this is 49 edges after accept.
- Throughput: at most one block per 1+NUM_ROUNDS*SBOX_STAGES+2 cycles. DONE→IDLE takes one cycle; there is no direct DONE→LOAD transition.
- in_valid outside IDLE is ignored and not queued.
- out_ready outside DONE is ignored.
- When out_ready=1 and in_valid=1 in the same DONE cycle, only out_ready takes effect. The new block is accepted in IDLE on a following cycle if in_valid is still high.
- Reset mid-LOAD/RUN/DONE: the block is discarded. out_valid is never asserted for it, and EN is 0 immediately (asynchronous).
- first_round and last_round are both 0 outside RUN. Both can be 1 together only when NUM_ROUNDS==1, which is disallowed.

Test Plan:
1. Reset release, in_valid pulse 1 cycle, out_ready=1 → load_sel high 1 cycle; round 15,15,15,14,...,0; stage 0,1,2 repeating; out_valid high 49 edges after accept for 1 cycle; back to IDLE with in_ready=1.
2. out_ready=0 for 10 cycles after out_valid rises → out_valid, round=0 and EN=0 held 10 cycles; out_valid drops the cycle after out_ready=1.
3. in_valid held high continuously, out_ready=1 → blocks accepted every 51 cycles; in_ready low throughout LOAD/RUN/DONE.
4. Assert reset asynchronously mid-RUN at round=7, stage=1 → EN=0, busy=0, round=0 without waiting for clk; no out_valid follows.
5. SBOX_STAGES=1, NUM_ROUNDS=16 → stage always 0; round decrements every cycle; out_valid 17 edges after accept.
6. first_round/last_round → first_round high only during the 3 RUN cycles with round=15; last_round high only during the 3 RUN cycles with round=0.
